// File: rtl/traffic_b_detector_if.sv
// Signal bundle between the lane-B loop pad, the detector and the traffic light controller.
// The detector drives the slave side; a driver or testbench takes the master side.
interface traffic_b_detector_if #(
    parameter int CNT_W = 8
);
    // Handshake: traffic_B is a level request that stays high until green_light_B
    // acknowledges it; the acknowledge counts only once the request is already latched.
    logic             loop_raw;
    logic             green_light_B;
    logic             cnt_clr;
    logic             traffic_B;
    logic             presence;
    logic [CNT_W-1:0] vehicle_cnt;
    logic             det_fault;

    modport slave (
        input  loop_raw, green_light_B, cnt_clr,
        output traffic_B, presence, vehicle_cnt, det_fault
    );

    modport master (
        output loop_raw, green_light_B, cnt_clr,
        input  traffic_B, presence, vehicle_cnt, det_fault
    );
endinterface

// File: rtl/traffic_b_detector.sv
// Lane-B vehicle detector: sync + debounce of the loop, latched demand until served, arrival count.
// Define DET_STUCK_FAULT_EN to add the stuck-loop monitor and the fail-safe FAULT state.
module traffic_b_detector #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8,
    parameter int STUCK_CYCLES    = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    traffic_b_detector_if.slave         det,
    output logic [1:0]                  state_dbg
);
    localparam int               DEB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
`ifdef DET_STUCK_FAULT_EN
        , FAULT = 2'd3
`endif
    } state_t;

    logic             s1, s2;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_hit;
    logic             presence_q, presence_d, presence_n;
    logic             rise;
    logic [CNT_W-1:0] cnt_q;
    state_t           state_q, state_n;
    logic             traffic_q, traffic_n;

    assign deb_hit    = (s2 != presence_q) && (deb_cnt == DEB_LAST);
    assign presence_n = deb_hit ? ~presence_q : presence_q;
    // An arrival is the first cycle the debounced presence is seen high.
    assign rise       = presence_q & ~presence_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            deb_cnt    <= '0;
            presence_q <= 1'b0;
            presence_d <= 1'b0;
        end else begin
            s1         <= det.loop_raw;
            s2         <= s1;
            presence_q <= presence_n;
            presence_d <= presence_q;
            if ((s2 == presence_q) || deb_hit) deb_cnt <= '0;
            else                               deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                         cnt_q <= '0;
        else if (det.cnt_clr)            cnt_q <= rise ? CNT_W'(1) : '0;
        else if (rise && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end

`ifdef DET_STUCK_FAULT_EN
    localparam int               STUCK_W    = $clog2(STUCK_CYCLES + 1);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

    logic [STUCK_W-1:0] stuck_cnt;
    logic               stuck_hit;
    logic               fault_q, fault_n;

    // Counter parks one short of the limit, so the hit stays asserted while the loop stays on.
    assign stuck_hit = presence_q && (stuck_cnt == STUCK_LAST);

    always_ff @(posedge clk) begin
        if (rst || !presence_q)          stuck_cnt <= '0;
        else if (stuck_cnt != STUCK_LAST) stuck_cnt <= stuck_cnt + STUCK_W'(1);
    end
`else
    // STUCK_CYCLES only matters when the stuck-loop monitor is built in.
    logic unused_stuck_cfg;
    assign unused_stuck_cfg = ^STUCK_CYCLES;
`endif

    always_comb begin
        state_n   = state_q;
        traffic_n = 1'b0;
`ifdef DET_STUCK_FAULT_EN
        fault_n   = 1'b0;
`endif
        case (state_q)
            IDLE:    if (rise) state_n = REQ;
            REQ:     if (det.green_light_B) state_n = SERVE;
            SERVE:   if (!det.green_light_B) state_n = presence_q ? REQ : IDLE;
`ifdef DET_STUCK_FAULT_EN
            FAULT:   if (!presence_q) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
`ifdef DET_STUCK_FAULT_EN
        if (stuck_hit) state_n = FAULT;
`endif
        // Outputs are registered from the next-state decode so they line up with state_q.
        case (state_n)
            REQ:     traffic_n = 1'b1;
            SERVE:   traffic_n = presence_n;
`ifdef DET_STUCK_FAULT_EN
            FAULT: begin
                traffic_n = 1'b1;
                fault_n   = 1'b1;
            end
`endif
            default: traffic_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            traffic_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            traffic_q <= traffic_n;
        end
    end

`ifdef DET_STUCK_FAULT_EN
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_n;
    end
    assign det.det_fault = fault_q;
`else
    assign det.det_fault = 1'b0;
`endif

    assign det.traffic_B   = traffic_q;
    assign det.presence    = presence_q;
    assign det.vehicle_cnt = cnt_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_traffic_b_detector.sv
// Bench for traffic_b_detector: directed steps plus random loop/green traffic, checked each cycle
// against a history-based reference model of presence, demand and arrival count.
module tb_traffic_b_detector;
    localparam int DEB   = 8;
    localparam int CW    = 8;
    localparam int STUCK = 50;
    localparam int EW    = CW + 3;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef DET_STUCK_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    // Demand phases of the reference model.
    localparam int D_NONE    = 0;
    localparam int D_WAITING = 1;
    localparam int D_SERVED  = 2;
    localparam int D_FAULT   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         errors = 0;
    logic [EW-1:0] exp_q[$];

    traffic_b_detector_if #(.CNT_W(CW)) det_if ();

    traffic_b_detector #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(CW),
        .STUCK_CYCLES(STUCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .det(det_if),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Presence flips once the raw samples taken 2..DEB+1 edges ago all disagree with it.
    bit raw_hist[$];
    bit m_pres, m_pres_d;
    int m_run, m_cnt, m_phase;

    always @(posedge clk) begin
        bit differ, nxt_p, arrival, exp_tb;
        if (rst) begin
            raw_hist.delete();
            repeat (DEB + 2) raw_hist.push_back(1'b0);
            m_pres = 0; m_pres_d = 0; m_run = 0; m_cnt = 0; m_phase = D_NONE;
            exp_q.push_back('0);
        end else begin
            differ = 1'b1;
            for (int j = 2; j <= DEB + 1; j++)
                if (raw_hist[raw_hist.size() - j] == m_pres) differ = 1'b0;
            nxt_p   = differ ? !m_pres : m_pres;
            arrival = m_pres && !m_pres_d;
            if (det_if.cnt_clr) m_cnt = arrival ? 1 : 0;
            else if (arrival && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_run = m_pres ? m_run + 1 : 0;
            case (m_phase)
                D_NONE:    if (arrival) m_phase = D_WAITING;
                D_WAITING: if (det_if.green_light_B) m_phase = D_SERVED;
                D_SERVED:  if (!det_if.green_light_B) m_phase = m_pres ? D_WAITING : D_NONE;
                D_FAULT:   if (!m_pres) m_phase = D_NONE;
                default:   m_phase = D_NONE;
            endcase
            if (FAULT_EN && m_run >= STUCK) m_phase = D_FAULT;
            exp_tb = (m_phase == D_WAITING) || (m_phase == D_FAULT) ||
                     ((m_phase == D_SERVED) && nxt_p);
            m_pres_d = m_pres;
            m_pres   = nxt_p;
            raw_hist.push_back(det_if.loop_raw);
            if (raw_hist.size() > 32) void'(raw_hist.pop_front());
            exp_q.push_back({exp_tb, nxt_p, (m_phase == D_FAULT), m_cnt[CW-1:0]});
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        logic [EW-1:0] e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed 0 expected 1 entries");
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("sb_traffic_B", 32'(det_if.traffic_B), 32'(e[EW-1]));
        chk("sb_presence", 32'(det_if.presence), 32'(e[EW-2]));
        chk("sb_det_fault", 32'(det_if.det_fault), 32'(e[EW-3]));
        chk("sb_vehicle_cnt", 32'(det_if.vehicle_cnt), 32'(e[CW-1:0]));
    endtask

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic drive(input bit raw, input bit grn, input bit clr);
        det_if.loop_raw      = raw;
        det_if.green_light_B = grn;
        det_if.cnt_clr       = clr;
    endtask

    task automatic wait_presence(input bit val, input int budget, output int n);
        n = 0;
        while (det_if.presence !== val && n < budget) begin
            step(1);
            n++;
        end
        chk("wait_presence", 32'(det_if.presence), 32'(val));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        drive(1'b1, 1'b0, 1'b0);
        rst = 1'b1;

        // reset with loop held high, then sync+debounce latency
        step(2);
        chk("rst_presence", 32'(det_if.presence), 32'd0);
        chk("rst_traffic_B", 32'(det_if.traffic_B), 32'd0);
        chk("rst_vehicle_cnt", 32'(det_if.vehicle_cnt), 32'd0);
        chk("rst_det_fault", 32'(det_if.det_fault), 32'd0);
        rst = 1'b0;
        step(9);
        chk("lat_presence_early", 32'(det_if.presence), 32'd0);
        step(1);
        chk("lat_presence", 32'(det_if.presence), 32'd1);
        chk("lat_traffic_B_early", 32'(det_if.traffic_B), 32'd0);
        step(1);
        chk("lat_traffic_B", 32'(det_if.traffic_B), 32'd1);

        // reset mid-operation discards the latched demand
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("midrst_traffic_B", 32'(det_if.traffic_B), 32'd0);
        chk("midrst_state", 32'(state_dbg), 32'd0);
        step(12);

        // glitch rejection
        drive(1'b1, 1'b0, 1'b0);
        step(5);
        drive(1'b0, 1'b0, 1'b0);
        step(15);
        chk("glitch_presence", 32'(det_if.presence), 32'd0);
        chk("glitch_traffic_B", 32'(det_if.traffic_B), 32'd0);
        chk("glitch_vehicle_cnt", 32'(det_if.vehicle_cnt), 32'd0);

        // latch and serve
        drive(1'b1, 1'b0, 1'b0);
        step(20);
        drive(1'b0, 1'b0, 1'b0);
        step(15);
        chk("latch_presence_gone", 32'(det_if.presence), 32'd0);
        chk("latch_traffic_B", 32'(det_if.traffic_B), 32'd1);
        drive(1'b0, 1'b1, 1'b0);
        step(10);
        chk("serve_empty_traffic_B", 32'(det_if.traffic_B), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        step(2);
        chk("served_traffic_B", 32'(det_if.traffic_B), 32'd0);
        chk("served_state_idle", 32'(state_dbg), 32'd0);
        chk("served_vehicle_cnt", 32'(det_if.vehicle_cnt), 32'd1);

        // continued demand through green falling
        drive(1'b1, 1'b0, 1'b0);
        wait_presence(1'b1, 30, n);
        step(2);
        chk("cont_req_traffic_B", 32'(det_if.traffic_B), 32'd1);
        drive(1'b1, 1'b1, 1'b0);
        step(5);
        chk("cont_serve_traffic_B", 32'(det_if.traffic_B), 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        step(3);
        chk("cont_rereq_traffic_B", 32'(det_if.traffic_B), 32'd1);
        chk("cont_vehicle_cnt", 32'(det_if.vehicle_cnt), 32'd2);
        drive(1'b0, 1'b0, 1'b0);
        wait_presence(1'b0, 30, n);
        step(3);
        chk("cont_latched_traffic_B", 32'(det_if.traffic_B), 32'd1);
        drive(1'b0, 1'b1, 1'b0);
        step(3);
        drive(1'b0, 1'b0, 1'b0);
        step(2);
        chk("cont_done_traffic_B", 32'(det_if.traffic_B), 32'd0);

        // saturating counter with random dwell times and random green
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            step($urandom_range(9, 14));
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            step($urandom_range(9, 14));
        end
        drive(1'b0, 1'b0, 1'b0);
        step(12);
        chk("cnt_saturate", 32'(det_if.vehicle_cnt), 32'd255);
        drive(1'b0, 1'b0, 1'b1);
        step(1);
        drive(1'b0, 1'b0, 1'b0);
        chk("cnt_clear", 32'(det_if.vehicle_cnt), 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        wait_presence(1'b1, 30, n);
        drive(1'b1, 1'b0, 1'b1);
        step(1);
        drive(1'b1, 1'b0, 1'b0);
        chk("cnt_clear_with_rise", 32'(det_if.vehicle_cnt), 32'd1);
        drive(1'b0, 1'b1, 1'b0);
        step(12);

        // random traffic against the model
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0));
            step(1);
            det_if.cnt_clr = 1'b0;
            step($urandom_range(0, 20));
        end

        // stuck loop
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        drive(1'b1, 1'b0, 1'b0);
        wait_presence(1'b1, 30, n);
        step(49);
        chk("stuck_early_det_fault", 32'(det_if.det_fault), 32'd0);
        step(1);
        chk("stuck_det_fault", 32'(det_if.det_fault), 32'(FAULT_EN));
        chk("stuck_traffic_B", 32'(det_if.traffic_B), 32'd1);
        step(10);
        drive(1'b0, 1'b0, 1'b0);
        wait_presence(1'b0, 30, n);
        step(1);
        chk("unstuck_det_fault", 32'(det_if.det_fault), 32'd0);
        chk("unstuck_traffic_B", 32'(det_if.traffic_B), 32'(!FAULT_EN));
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
